counter_sequencer: RTL and testbench

//  Run controller for the 8-bit T-flip-flop counter. Drives the counter's Enable and Clear_b

---
 rtl/counter_ctrl_pkg.sv | 34 +++
 rtl/counter_sequencer_rate_divider.sv | 40 ++++
 rtl/counter_sequencer.sv | 131 +++++++++++++
 tb/tb_counter_sequencer.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_ctrl_pkg.sv
// Shared types and helpers for the counter run controller.
// State encoding, rate codes and the divider reload value per rate.
package counter_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam logic [1:0] RATE_FAST       = 2'b00;
    localparam logic [1:0] RATE_1HZ        = 2'b01;
    localparam logic [1:0] RATE_HALF_HZ    = 2'b10;
    localparam logic [1:0] RATE_QUARTER_HZ = 2'b11;

    // Divider reload: a pulse is issued every reload+1 RUN cycles.
    function automatic int unsigned reload_value(
        input logic [1:0]  rate,
        input int unsigned ticks
    );
        int unsigned r;
        r = 0;
        unique case (rate)
            RATE_FAST:       r = 0;
            RATE_1HZ:        r = ticks - 1;
            RATE_HALF_HZ:    r = 2 * ticks - 1;
            RATE_QUARTER_HZ: r = 4 * ticks - 1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/counter_sequencer_rate_divider.sv
// Down-counter rate divider: load, decrement/reload on step, hold on freeze.
// Ports: clk_i, rst_ni (sync, active-low), load_i, step_i, freeze_i,
//        reload_i [W], zero_o (divider currently at zero).
module rate_divider
    import counter_ctrl_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic         step_i,
    input  logic         freeze_i,
    input  logic [W-1:0] reload_i,
    output logic         zero_o
);

    logic [W-1:0] div_q;
    logic [W-1:0] div_d;

    always_comb begin
        div_d = div_q;
        if (load_i) begin
            div_d = reload_i;
        end else if (step_i && !freeze_i) begin
            div_d = (div_q == '0) ? reload_i : div_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign zero_o = (div_q == '0);

endmodule

// File: rtl/counter_sequencer.sv
// Run controller for the T-flip-flop counter: start/stop/pause, rate divider,
// stop at Target. Build macro AUTO_RELOAD_EN: a match restarts the run and
// pulses Done for one cycle instead of parking in DONE.
// Ports: Clock, Clear_b (sync, active-low reset), Start, Stop, Pause,
//        Rate[2], Target[WIDTH], CountValue[WIDTH] in;
//        CountEnable, CountClear_b, Done, Running out.
module counter_sequencer
    import counter_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned TICKS_PER_SEC = 50000000
) (
    input  logic             Clock,
    input  logic             Clear_b,
    input  logic             Start,
    input  logic             Stop,
    input  logic             Pause,
    input  logic [1:0]       Rate,
    input  logic [WIDTH-1:0] Target,
    input  logic [WIDTH-1:0] CountValue,
    output logic             CountEnable,
    output logic             CountClear_b,
    output logic             Done,
    output logic             Running
);

    localparam int unsigned DIV_W = $clog2(4 * TICKS_PER_SEC);

    state_e            state_q;
    state_e            state_d;
    logic              div_zero;
    logic              match;
    logic              go;
    logic              done_raw;
    logic [DIV_W-1:0]  reload;

    assign reload = DIV_W'(reload_value(Rate, TICKS_PER_SEC));
    assign match  = (CountValue == Target);
    assign go     = Start & ~Stop;

`ifdef AUTO_RELOAD_EN
    // Marks a CLEAR entered from a target match, so Done pulses only then.
    logic rearm_q;
    logic rearm_d;
`endif

    always_comb begin
        state_d = state_q;
`ifdef AUTO_RELOAD_EN
        rearm_d = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (go) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (Stop) begin
                    state_d = ST_IDLE;
                end else if (Pause) begin
                    state_d = ST_PAUSE;
                end else if (match) begin
`ifdef AUTO_RELOAD_EN
                    state_d = ST_CLEAR;
                    rearm_d = 1'b1;
`else
                    state_d = ST_DONE;
`endif
                end
            end
            ST_PAUSE: begin
                if (Stop) begin
                    state_d = ST_IDLE;
                end else if (!Pause) begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (go) state_d = ST_CLEAR;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Clear_b) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef AUTO_RELOAD_EN
    always_ff @(posedge Clock) begin
        if (!Clear_b) begin
            rearm_q <= 1'b0;
        end else begin
            rearm_q <= rearm_d;
        end
    end

    assign done_raw = (state_q == ST_CLEAR) & rearm_q;
`else
    assign done_raw = (state_q == ST_DONE);
`endif

    // Divider only advances in RUN and is frozen while Pause is held,
    // so a pulse deferred by a pause is issued on resume.
    rate_divider #(
        .W (DIV_W)
    ) u_div (
        .clk_i    (Clock),
        .rst_ni   (Clear_b),
        .load_i   (state_q == ST_CLEAR),
        .step_i   (state_q == ST_RUN),
        .freeze_i (Pause),
        .reload_i (reload),
        .zero_o   (div_zero)
    );

    // Gating with Clear_b drops a pulse that coincides with reset.
    assign CountEnable  = Clear_b & (state_q == ST_RUN) & div_zero
                        & ~match & ~Stop & ~Pause;
    assign CountClear_b = Clear_b & (state_q != ST_CLEAR);
    assign Done         = Clear_b & done_raw;
    assign Running      = Clear_b & ((state_q == ST_RUN) |
                                     (state_q == ST_PAUSE));

endmodule

// File: tb/tb_counter_sequencer.sv
// Testbench for counter_sequencer with a TFF counter model on its outputs.
// Directed scenarios plus randomized traffic against a behavioural model.
module tb_counter_sequencer;

    localparam int T = 4;

`ifdef AUTO_RELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       Clock      = 1'b0;
    logic       Clear_b    = 1'b0;
    logic       Start      = 1'b0;
    logic       Stop       = 1'b0;
    logic       Pause      = 1'b0;
    logic [1:0] Rate       = 2'b00;
    logic [7:0] Target     = 8'd0;
    logic [7:0] CountValue = 8'd0;
    logic       CountEnable;
    logic       CountClear_b;
    logic       Done;
    logic       Running;

    int total = 0;
    int bad   = 0;

    counter_sequencer #(
        .WIDTH         (8),
        .TICKS_PER_SEC (T)
    ) dut (
        .Clock        (Clock),
        .Clear_b      (Clear_b),
        .Start        (Start),
        .Stop         (Stop),
        .Pause        (Pause),
        .Rate         (Rate),
        .Target       (Target),
        .CountValue   (CountValue),
        .CountEnable  (CountEnable),
        .CountClear_b (CountClear_b),
        .Done         (Done),
        .Running      (Running)
    );

    always #5 Clock = ~Clock;

    // The counter being controlled.
    always @(posedge Clock) begin
        if (!CountClear_b) CountValue <= 8'd0;
        else if (CountEnable) CountValue <= CountValue + 8'd1;
    end

    // Behavioural reference: mode, cycles left before the next pulse,
    // expected counter value.
    typedef enum int {M_IDLE, M_CLEAR, M_RUN, M_PAUSE, M_DONE} mode_t;
    mode_t md    = M_IDLE;
    int    left  = 0;
    int    cnt_e = 0;
    bit    rearm = 1'b0;
    bit    e_en, e_clr, e_done, e_run;
    logic [11:0] obs, expv;

    function automatic int period(input logic [1:0] r);
        case (r)
            2'd0:    return 1;
            2'd1:    return T;
            2'd2:    return 2 * T;
            default: return 4 * T;
        endcase
    endfunction

    task automatic predict();
        e_en   = Clear_b && md == M_RUN && left == 0 &&
                 cnt_e != int'(Target) && !Stop && !Pause;
        e_clr  = Clear_b && md != M_CLEAR;
        e_done = Clear_b && (AUTO ? (md == M_CLEAR && rearm)
                                  : (md == M_DONE));
        e_run  = Clear_b && (md == M_RUN || md == M_PAUSE);
        obs  = {CountEnable, CountClear_b, Done, Running, CountValue};
        expv = {e_en, e_clr, e_done, e_run, cnt_e[7:0]};
    endtask

    task automatic model_next();
        bit hit;
        bit nr;
        int per;
        predict();
        if (!Clear_b) begin
            md = M_IDLE; left = 0; cnt_e = 0; rearm = 1'b0;
        end else begin
            hit = (cnt_e == int'(Target));
            per = period(Rate);
            nr  = 1'b0;
            if (md == M_CLEAR) cnt_e = 0;
            else if (e_en) cnt_e = (cnt_e + 1) % 256;
            case (md)
                M_IDLE, M_DONE: if (Start && !Stop) md = M_CLEAR;
                M_CLEAR: begin md = M_RUN; left = per - 1; end
                M_RUN: begin
                    if (!Pause) left = (left == 0) ? per - 1 : left - 1;
                    if (Stop) md = M_IDLE;
                    else if (Pause) md = M_PAUSE;
                    else if (hit) begin
                        if (AUTO) begin md = M_CLEAR; nr = 1'b1; end
                        else md = M_DONE;
                    end
                end
                M_PAUSE: begin
                    if (Stop) md = M_IDLE;
                    else if (!Pause) md = M_RUN;
                end
                default: md = M_IDLE;
            endcase
            rearm = nr;
        end
    endtask

    task automatic adv();
        model_next();
        @(posedge Clock);
        #1;
    endtask

    task automatic settle();
        @(negedge Clock);
        predict();
    endtask

    task automatic test_reset();
        Clear_b = 1'b0;
        for (int i = 0; i < 2; i++) begin
            settle();
            total++;
            if (obs[11:8] !== 4'b0000) begin
                bad++;
                $display("FAIL reset_outs got=%b want=0000", obs[11:8]);
            end
            adv();
        end
        Clear_b = 1'b1;
        settle();
        total++;
        if (obs[11:8] !== 4'b0100) begin
            bad++;
            $display("FAIL reset_release got=%b want=0100", obs[11:8]);
        end
        adv();
    endtask

    task automatic test_fast_run();
        int pulses = 0;
        Rate = 2'b00; Target = 8'd5; Start = 1'b1;
        settle(); adv();
        Start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            settle();
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL fast_run c%0d got=%h want=%h", i, obs, expv);
            end
            if (i == 0) begin
                total++;
                if (CountClear_b !== 1'b0) begin
                    bad++;
                    $display("FAIL fast_clear got=%b want=0", CountClear_b);
                end
            end
            if (CountEnable === 1'b1) pulses++;
            adv();
        end
        settle();
        total++;
        if (pulses != 5 || Done !== 1'b1 || CountValue !== 8'd5) begin
            bad++;
            $display("FAIL fast_done got=%0d/%b/%0d want=5/1/5",
                     pulses, Done, CountValue);
        end
        adv();
    endtask

    task automatic test_slow_run();
        int p[$];
        int c3 = -1;
        int dn = -1;
        Rate = 2'b01; Target = 8'd3; Start = 1'b1;
        settle(); adv();
        Start = 1'b0;
        for (int i = 0; i < 25; i++) begin
            settle();
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL slow_run c%0d got=%h want=%h", i, obs, expv);
            end
            if (CountEnable === 1'b1) p.push_back(i);
            if (c3 < 0 && CountValue === 8'd3) c3 = i;
            if (dn < 0 && Done === 1'b1) dn = i;
            adv();
        end
        total++;
        if (p.size() != 3 || p[0] != 4 || p[1] != 8 || p[2] != 12) begin
            bad++;
            $display("FAIL slow_pulses got=%0d pulses first=%0d want=3 at 4,8,12",
                     p.size(), (p.size() > 0) ? p[0] : -1);
        end
        total++;
        if (c3 < 0 || dn - c3 != 1) begin
            bad++;
            $display("FAIL slow_done_lat got=%0d want=1", dn - c3);
        end
    endtask

    task automatic test_pause();
        int n = 0;
        int d = 0;
        Rate = 2'b01; Target = 8'd50; Start = 1'b1;
        settle(); adv();
        Start = 1'b0;
        while (CountValue !== 8'd1 && n < 40) begin
            settle(); adv(); n++;
        end
        total++;
        if (n >= 40) begin
            bad++;
            $display("FAIL pause_reach got=%0d want=1", CountValue);
        end
        Pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            settle();
            total++;
            if (obs !== expv || CountEnable !== 1'b0 || Running !== 1'b1) begin
                bad++;
                $display("FAIL pause_hold c%0d got=%h want=%h", i, obs, expv);
            end
            adv();
        end
        Pause = 1'b0;
        forever begin
            settle();
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL pause_resume got=%h want=%h", obs, expv);
            end
            if (CountEnable === 1'b1 || d > 20) break;
            adv(); d++;
        end
        adv();
        // Three divider counts remained plus the cycle leaving PAUSE.
        total++;
        if (d != T) begin
            bad++;
            $display("FAIL pause_gap got=%0d want=%0d", d, T);
        end
        Stop = 1'b1;
        settle(); adv();
        Stop = 1'b0;
    endtask

    task automatic test_target_zero();
        int pulses = 0;
        Rate = 2'b00; Target = 8'd0; Start = 1'b1;
        settle(); adv();
        Start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            settle();
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL tzero c%0d got=%h want=%h", i, obs, expv);
            end
            if (CountEnable === 1'b1) pulses++;
            adv();
        end
        settle();
        total++;
        if (pulses != 0 || Done !== 1'b1) begin
            bad++;
            $display("FAIL tzero_done got=%0d/%b want=0/1", pulses, Done);
        end
        adv();
    endtask

    task automatic test_stop();
        int n = 0;
        Rate = 2'b01; Target = 8'd50; Start = 1'b1;
        settle(); adv();
        Start = 1'b0;
        while (CountValue !== 8'd2 && n < 40) begin
            settle(); adv(); n++;
        end
        Stop = 1'b1;
        settle();
        total++;
        if (n >= 40 || CountEnable !== 1'b0) begin
            bad++;
            $display("FAIL stop_en got=%b/%0d want=0/2", CountEnable, CountValue);
        end
        adv();
        Stop = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            total++;
            if (obs !== expv || Running !== 1'b0 || CountValue !== 8'd2) begin
                bad++;
                $display("FAIL stop_hold c%0d got=%h want=%h", i, obs, expv);
            end
            adv();
        end
        Start = 1'b1; Stop = 1'b1;
        settle(); adv();
        Start = 1'b0; Stop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            total++;
            if (obs !== expv || CountClear_b !== 1'b1 || Running !== 1'b0) begin
                bad++;
                $display("FAIL start_stop c%0d got=%h want=%h", i, obs, expv);
            end
            adv();
        end
    endtask

    task automatic test_auto_reload();
        int dn = 0;
        int want;
        want = AUTO ? 3 : 12;
        Rate = 2'b00; Target = 8'd2; Start = 1'b1;
        settle(); adv();
        Start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            settle();
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL auto c%0d got=%h want=%h", i, obs, expv);
            end
            if (Done === 1'b1) dn++;
            adv();
        end
        total++;
        if (dn != want) begin
            bad++;
            $display("FAIL auto_done_cnt got=%0d want=%0d", dn, want);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 2500; i++) begin
            Clear_b = ($urandom_range(0, 199) != 0);
            Start   = ($urandom_range(0, 7) == 0);
            Stop    = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 11) == 0) Pause = ~Pause;
            if ($urandom_range(0, 49) == 0) Rate = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 79) == 0)
                Target = ($urandom_range(0, 3) == 0) ?
                         8'($urandom_range(0, 255)) : 8'($urandom_range(0, 12));
            settle();
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL random c%0d got=%h want=%h", i, obs, expv);
            end
            adv();
        end
    endtask

    initial begin
        test_reset();
        test_fast_run();
        test_slow_run();
        test_pause();
        test_target_zero();
        test_stop();
        test_auto_reload();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
